apb0_root_arb: RTL

APB0_ROOT_ARB -- requirements
Module: apb0_root_arb

---
 rtl/apb0_root_arb_if.sv | 39 +++
 rtl/apb0_root_arb.sv | 104 ++++++++++
 2 files changed

// File: rtl/apb0_root_arb_if.sv
// Bundle of requester-side and APB-root-side signals for apb0_root_arb.
// The master modport is the arbiter; the slave modport is the environment (requesters and the leaf mux).
interface apb0_root_arb_if;
  logic [1:0]  i_req;
  logic [63:0] i_addr;
  logic [63:0] i_wdata;
  logic [7:0]  i_strb;
  logic [1:0]  i_write;
  logic [5:0]  i_prot;
  logic [1:0]  o_ack;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_root_psel;
  logic        o_root_penable;
  logic        o_root_pwrite;
  logic [31:0] o_root_paddr;
  logic [31:0] o_root_pwdata;
  logic [3:0]  o_root_pstrb;
  logic [2:0]  o_root_pprot;
  logic        i_root_pready;
  logic        i_root_pslverr;
  logic [31:0] i_root_prdata;

  modport master (
    input  i_req, i_addr, i_wdata, i_strb, i_write, i_prot,
    input  i_root_pready, i_root_pslverr, i_root_prdata,
    output o_ack, o_rdata, o_err,
    output o_root_psel, o_root_penable, o_root_pwrite,
    output o_root_paddr, o_root_pwdata, o_root_pstrb, o_root_pprot
  );

  modport slave (
    output i_req, i_addr, i_wdata, i_strb, i_write, i_prot,
    output i_root_pready, i_root_pslverr, i_root_prdata,
    input  o_ack, o_rdata, o_err,
    input  o_root_psel, o_root_penable, o_root_pwrite,
    input  o_root_paddr, o_root_pwdata, o_root_pstrb, o_root_pprot
  );
endinterface

// File: rtl/apb0_root_arb.sv
// Two-requester round-robin APB root arbiter with fully registered outputs.
// Optional ACCESS timeout is built only when APB0_ARB_TIMEOUT_EN is defined.
module apb0_root_arb #(
  parameter int unsigned APB_TIMEOUT_CYC = 255
) (
  input logic             i_pclk,
  input logic             i_prst,
  apb0_root_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state;
  logic   last;
  logic   win;
  logic   sel;

  if (APB_TIMEOUT_CYC < 1 || APB_TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("apb0_root_arb: APB_TIMEOUT_CYC out of range 1..65535");
  end

  // Tie goes to the requester not granted last; a lone requester always wins.
  always_comb begin
    sel = bus.i_req[1];
    if (bus.i_req == 2'b11) sel = ~last;
  end

`ifdef APB0_ARB_TIMEOUT_EN
  logic [15:0] tcnt;
`endif

  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      state              <= IDLE;
      last               <= 1'b1;
      win                <= 1'b0;
      bus.o_ack          <= '0;
      bus.o_rdata        <= '0;
      bus.o_err          <= 1'b0;
      bus.o_root_psel    <= 1'b0;
      bus.o_root_penable <= 1'b0;
      bus.o_root_pwrite  <= 1'b0;
      bus.o_root_paddr   <= '0;
      bus.o_root_pwdata  <= '0;
      bus.o_root_pstrb   <= '0;
      bus.o_root_pprot   <= '0;
`ifdef APB0_ARB_TIMEOUT_EN
      tcnt               <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.i_req) begin
            win                <= sel;
            bus.o_root_paddr   <= bus.i_addr[32*sel +: 32];
            bus.o_root_pwdata  <= bus.i_wdata[32*sel +: 32];
            bus.o_root_pstrb   <= bus.i_strb[4*sel +: 4];
            bus.o_root_pwrite  <= bus.i_write[sel];
            bus.o_root_pprot   <= bus.i_prot[3*sel +: 3];
            bus.o_root_psel    <= 1'b1;
            bus.o_root_penable <= 1'b0;
            state              <= SETUP;
          end
        end
        SETUP: begin
          bus.o_root_penable <= 1'b1;
`ifdef APB0_ARB_TIMEOUT_EN
          tcnt               <= '0;
`endif
          state              <= ACCESS;
        end
        ACCESS: begin
          if (bus.i_root_pready) begin
            bus.o_rdata        <= bus.o_root_pwrite ? '0 : bus.i_root_prdata;
            bus.o_err          <= bus.i_root_pslverr;
            bus.o_ack          <= win ? 2'b10 : 2'b01;
            bus.o_root_psel    <= 1'b0;
            bus.o_root_penable <= 1'b0;
            state              <= DONE;
          end
`ifdef APB0_ARB_TIMEOUT_EN
          else if (tcnt == 16'(APB_TIMEOUT_CYC - 1)) begin
            bus.o_rdata        <= '0;
            bus.o_err          <= 1'b1;
            bus.o_ack          <= win ? 2'b10 : 2'b01;
            bus.o_root_psel    <= 1'b0;
            bus.o_root_penable <= 1'b0;
            state              <= DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end
        DONE: begin
          bus.o_ack <= '0;
          last      <= win;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
